// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/MEM requesters, the RAM arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the surrounding CPU + RAM environment.
interface mem_arbiter_if #(
   parameter int unsigned RAM_AW = 17
) ();
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_done;
   logic [31:0]       if_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_sel;
   logic              mem_done;
   logic [31:0]       mem_rdata;

   logic              ram_ce;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [3:0]        ram_sel;
   logic [31:0]       ram_rdata;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, ram_rdata,
      output if_done, if_rdata, mem_done, mem_rdata,
             ram_ce, ram_we, ram_addr, ram_wdata, ram_sel
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, ram_rdata,
      input  if_done, if_rdata, mem_done, mem_rdata,
             ram_ce, ram_we, ram_addr, ram_wdata, ram_sel
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port I/D RAM: fixed data priority, fixed-latency
// command/wait/done sequencing and little-endian <-> big-endian word byte reversal.
module mem_arbiter #(
   parameter int unsigned RAM_AW  = 17,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              gnt_data_q;

   logic              if_done_q;
   logic [31:0]       if_rdata_q;
   logic              mem_done_q;
   logic [31:0]       mem_rdata_q;
   logic              ram_ce_q;
   logic              ram_we_q;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [31:0]       ram_wdata_q;
   logic [3:0]        ram_sel_q;

   logic [31:0]       rdata_swap;
   logic              unused_addr_bits;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [3:0] rev4(input logic [3:0] s);
      return {s[0], s[1], s[2], s[3]};
   endfunction

   assign rdata_swap = bswap32(bus.ram_rdata);

   // Byte-offset and above-RAM address bits carry no meaning here.
   assign unused_addr_bits = ^{bus.if_addr[31:RAM_AW+2],  bus.if_addr[1:0],
                               bus.mem_addr[31:RAM_AW+2], bus.mem_addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         gnt_data_q  <= 1'b0;
         if_done_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= '0;
         ram_ce_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_sel_q   <= '0;
      end else begin
         ram_ce_q   <= 1'b0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Grant is latched here and held for the whole access.
               if (bus.mem_req) begin
                  gnt_data_q  <= 1'b1;
                  ram_ce_q    <= 1'b1;
                  ram_we_q    <= bus.mem_we;
                  ram_addr_q  <= bus.mem_addr[RAM_AW+1:2];
                  ram_wdata_q <= bswap32(bus.mem_wdata);
                  ram_sel_q   <= rev4(bus.mem_sel);
                  state_q     <= ST_CMD;
               end else if (bus.if_req) begin
                  gnt_data_q  <= 1'b0;
                  ram_ce_q    <= 1'b1;
                  ram_we_q    <= 1'b0;
                  ram_addr_q  <= bus.if_addr[RAM_AW+1:2];
                  ram_sel_q   <= 4'hF;
                  state_q     <= ST_CMD;
               end
            end
            ST_CMD: begin
               cnt_q   <= CNT_W'(MEM_LAT - 1);
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // cnt_q reaches zero exactly in the cycle ram_rdata is valid.
               if (cnt_q == '0) begin
                  if (gnt_data_q) begin
                     if (!ram_we_q) begin
                        mem_rdata_q <= rdata_swap;
                     end
                     mem_done_q <= 1'b1;
                  end else begin
                     if_rdata_q <= rdata_swap;
                     if_done_q  <= 1'b1;
                  end
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.if_done   = if_done_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.ram_ce    = ram_ce_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.ram_sel   = ram_sel_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester controller for the single-port instruction/data RAM. It sits between the fetch stage (`if_*`) and the MEM stage (`mem_*`) on one side and the RAM (`ram_*`) on the other. It sequences each access through a fixed-latency command/wait/done handshake and gives the data port fixed priority. It performs the word-level byte reversal between the CPU's little-endian view and the RAM's big-endian byte-per-lane storage.

## Interface
- `RAM_AW`, default 17: RAM word-address width. CPU byte address bits `[RAM_AW+1:2]` form the word index.
- `MEM_LAT`, default 2: number of cycles from the RAM command cycle to valid `ram_rdata`. Legal range is 1..15.
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `if_req`  in  1: fetch request. Held high until `if_done`.
- `if_addr`  in  32: fetch byte address. Held stable while `if_req` is high.
- `if_done`  out  1: one-cycle pulse; `if_rdata` is valid in this cycle.
- `if_rdata`  out  32: fetched instruction, little-endian.
- `mem_req`  in  1: data request. Held high until `mem_done`.
- `mem_we`  in  1: 1 = store, 0 = load. Held with `mem_req`.
- `mem_addr`  in  32: data byte address. Held with `mem_req`.
- `mem_wdata`  in  32: store data, little-endian. Held with `mem_req`.
- `mem_sel`  in  4: byte enables. Bit i enables CPU bits `[8i+7:8i]`.
- `mem_done`  out  1: one-cycle completion pulse, for loads and stores.
- `mem_rdata`  out  32: load data, little-endian. Valid in the `mem_done` cycle.
- `ram_ce`  out  1: RAM command strobe, registered.
- `ram_we`  out  1: RAM write enable, registered. Qualified by `ram_ce`.
- `ram_addr`  out  RAM_AW: RAM word address, registered.
- `ram_wdata`  out  32: RAM write data, registered, byte-reversed.
- `ram_sel`  out  4: RAM byte enables, registered, reversed.
- `ram_rdata`  in  32: RAM read data. Valid exactly `MEM_LAT` cycles after the `ram_ce` cycle.

## Operation
- States: IDLE, CMD, WAIT, DONE. Reset enters IDLE.
- **IDLE**
  - If `mem_req` is high: grant DATA, go to CMD.
  - Else if `if_req` is high: grant INST, go to CMD.
  - Else stay in IDLE.
  - On the transition, register the granted port's address, write enable, write data and byte enables onto the `ram_*` outputs.
- **CMD**
  - `ram_ce` = 1 for exactly one cycle.
  - For INST: `ram_we` = 0 and `ram_sel` = 4'hF.
  - Load the wait counter with `MEM_LAT`-1.
  - Go to WAIT, or directly to the capture step when `MEM_LAT` = 1.
- **WAIT**
  - `ram_ce` = 0. Decrement the counter each cycle.
  - In the cycle where `ram_rdata` is valid, capture the byte-reversed `ram_rdata` into the granted port's rdata register and go to DONE.
- **DONE**
  - Pulse the granted port's `_done` for one cycle, then go to IDLE.
  - `_req` is not sampled in DONE. A requester must drop or replace its request in the cycle after `_done`.
- **Byte reversal** (applies to `if_rdata`, `mem_rdata` and `ram_wdata`)
  - rdata = {r[7:0], r[15:8], r[23:16], r[31:24]}, where r = `ram_rdata`.
  - `ram_wdata` uses the same mapping applied to `mem_wdata`.
  - `ram_sel` = {`mem_sel[0]`, `mem_sel[1]`, `mem_sel[2]`, `mem_sel[3]`}.
- **Stores**
  - Use the same sequence as loads; `mem_done` is raised in the same cycle a load's would be.
  - `mem_rdata` holds its previous value.
- **Addressing**: address bits `[1:0]` are ignored. Alignment is the requester's responsibility.
- **Priority**
  - DATA has fixed priority over INST; INST may wait indefinitely while `mem_req` is continuously asserted.
  - The grant is fixed for the whole access. A request that arrives mid-access waits for IDLE.
- **Reset values**: `ram_ce`, `ram_we`, `if_done`, `mem_done` = 0; `ram_addr`, `ram_wdata`, `ram_sel`, `if_rdata`, `mem_rdata` = 0.
- **Reset mid-access**
  - Abort immediately to IDLE. No `_done` pulse is generated for the aborted access.
  - A write whose CMD cycle has already occurred is considered committed in the RAM.

## Timing
- Request first sampled high in IDLE at cycle T.
  - `ram_ce` is high at T+1.
  - `ram_rdata` is valid at T+1+`MEM_LAT`.
  - `_done` is high at T+2+`MEM_LAT`.
  - The FSM is back in IDLE at T+3+`MEM_LAT`, where the next request can be sampled.
- Peak throughput is one access per `MEM_LAT`+3 cycles. With `MEM_LAT` = 2 this is one access per 5 cycles.
- The first request sampled after reset is the one seen in the first cycle with `rst` low.
- Inputs `_req`, `_addr`, `_we`, `_wdata`, `_sel` are sampled only in IDLE. Later changes do not affect an in-flight access.

## Test plan
- **Single fetch**, `MEM_LAT` = 2. RAM word 0 = 32'h13000000; `if_req` goes high at T with `if_addr` = 0. Required: `ram_ce` = 1 and `ram_addr` = 0 at T+1; `if_done` at T+4 with `if_rdata` = 32'h00000013.
- **Store then load**. Store `mem_addr` = 32'h8, `mem_wdata` = 32'hAABBCCDD, `mem_sel` = 4'b0001. Required during the store CMD cycle: `ram_wdata` = 32'hDDCCBBAA, `ram_sel` = 4'b1000, `ram_addr` = 2. A following load of 32'h8 from RAM word 2 = 32'hDD000000 must return `mem_rdata` = 32'h000000DD.
- **Simultaneous requests**. `if_req` and `mem_req` both rise at T. Required: `mem_done` at T+4; INST is then granted from IDLE at T+5; `if_done` at T+9.
- **Continuous data requests**. `mem_req` is re-asserted immediately after every `mem_done` while `if_req` is held high. Required: `if_done` never pulses; each `mem_done` arrives exactly 5 cycles after the previous one.
- **Reset mid-access**. `rst` is asserted while in WAIT. Required: all outputs are 0 the next cycle; no `_done` pulse occurs; a request held through reset completes with `_done` at T'+4, where T' is the first cycle with `rst` low.
- **Latency sweep**. Run `MEM_LAT` = 1 and 5. Required: `_done` at T+3 and T+7 respectively, with the rdata captured from the cycle where `ram_rdata` is valid.
